dma_bus_controller: RTL and testbench

//  Bus-master sequencer for the DMA engine. Moves LEN words between memory (type 2'b00) and an IO device (type 2'b11).

---
 rtl/dma_bus_controller.sv | 214 +++++++++++++++++++++
 tb/tb_dma_bus_controller.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_bus_controller.sv
// dma_bus_controller
//   Bus-master sequencer for the DMA engine. Copies `len` words between
//   memory (bus_type 2'b00) and an IO device (bus_type 2'b11), one read into
//   an internal buffer followed by one write out of it per word. The shared
//   data bus is obtained from the CPU side through bus_req/bus_grant. At most
//   BURST_LEN words are moved per grant, then the request drops for a cycle
//   so the CPU side gets a chance at the bus.
//
// Bus handshake: while bus_valid=1 the op/type/addr (and wdata for writes)
//   are held stable; the cycle completes on the rising edge where bus_ready=1.
//   bus_ready is ignored while bus_valid=0. bus_grant is only looked at in
//   REQ and is expected to stay high for as long as bus_req stays high.
//
// Ports
//   clk, rst_n            clock (posedge), asynchronous active-low reset
//   start, dir            begin a transfer (IDLE only); 0 mem->IO, 1 IO->mem
//   src_addr, dst_addr    first source / destination address
//   len                   number of words (0 finishes without touching the bus)
//   abort                 stop at the next word boundary (sticky while busy)
//   bus_req, bus_grant    bus arbitration handshake
//   bus_valid, bus_op     cycle valid; 2'b01 read, 2'b00 write
//   bus_type, bus_addr    2'b00 memory / 2'b11 IO; current address
//   bus_rdata, bus_wdata  read data in, buffered write data out
//   bus_ready             slave completes the current cycle
//   busy, done, aborted   status: not idle, end pulse, ended early
//   words_left            words still to move
//   state_dbg             current FSM state, for debug and checkers
module dma_bus_controller #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 8,
    parameter int LEN_W     = 8,
    parameter int BURST_LEN = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              dir,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    input  logic              abort,
    output logic              bus_req,
    input  logic              bus_grant,
    output logic              bus_valid,
    output logic [1:0]        bus_op,
    output logic [1:0]        bus_type,
    output logic [ADDR_W-1:0] bus_addr,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ready,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [LEN_W-1:0]  words_left,
    output logic [2:0]        state_dbg
);

    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] TY_MEM   = 2'b00;
    localparam logic [1:0] TY_IO    = 2'b11;

    // Counter holds 0..BURST_LEN; BURST_LAST is the value seen in the NEXT
    // that finishes the final word of a grant.
    localparam int          BW         = $clog2(BURST_LEN + 1);
    localparam logic [BW-1:0] BURST_LAST = BW'(BURST_LEN - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        READ  = 3'd2,
        WRITE = 3'd3,
        NEXT  = 3'd4,
        REL   = 3'd5,
        DONE  = 3'd6
    } state_t;

    state_t              state_q, state_next;
    logic                dir_q;
    logic [ADDR_W-1:0]   src_q, dst_q;
    logic [LEN_W-1:0]    words_left_q;
    logic [DATA_W-1:0]   buffer_q;
    logic                abort_flag_q;
    logic                aborted_q;
    logic [BW-1:0]       burst_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    always_comb begin
        state_next = state_q;
        bus_req    = 1'b0;
        bus_valid  = 1'b0;
        bus_op     = OP_WRITE;
        bus_type   = TY_MEM;
        bus_addr   = '0;
        bus_wdata  = '0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_next = (len == '0) ? DONE : REQ;
                end
            end
            REQ: begin
                bus_req = 1'b1;
                if (bus_grant) begin
                    state_next = abort_flag_q ? DONE : READ;
                end
            end
            READ: begin
                bus_req   = 1'b1;
                bus_valid = 1'b1;
                bus_op    = OP_READ;
                bus_type  = dir_q ? TY_IO : TY_MEM;
                bus_addr  = src_q;
                if (bus_ready) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                bus_req   = 1'b1;
                bus_valid = 1'b1;
                bus_op    = OP_WRITE;
                bus_type  = dir_q ? TY_MEM : TY_IO;
                bus_addr  = dst_q;
                bus_wdata = buffer_q;
                if (bus_ready) begin
                    state_next = NEXT;
                end
            end
            NEXT: begin
                bus_req = 1'b1;
                // words_left still holds the pre-decrement count here.
                if (words_left_q == LEN_W'(1) || abort_flag_q) begin
                    state_next = DONE;
                end else if (burst_cnt_q == BURST_LAST) begin
                    state_next = REL;
                end else begin
                    state_next = READ;
                end
            end
            REL:     state_next = REQ;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_q        <= 1'b0;
            src_q        <= '0;
            dst_q        <= '0;
            words_left_q <= '0;
            buffer_q     <= '0;
            abort_flag_q <= 1'b0;
            aborted_q    <= 1'b0;
            burst_cnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        dir_q        <= dir;
                        src_q        <= src_addr;
                        dst_q        <= dst_addr;
                        words_left_q <= len;
                        abort_flag_q <= 1'b0;
                        aborted_q    <= 1'b0;
                        burst_cnt_q  <= '0;
                    end
                end
                READ: begin
                    if (bus_ready) begin
                        buffer_q <= bus_rdata;
                    end
                end
                NEXT: begin
                    words_left_q <= words_left_q - LEN_W'(1);
                    burst_cnt_q  <= burst_cnt_q + BW'(1);
                    // Only the memory-side address walks; the IO port is fixed.
                    if (dir_q) begin
                        dst_q <= dst_q + ADDR_W'(1);
                    end else begin
                        src_q <= src_q + ADDR_W'(1);
                    end
                end
                REL:     burst_cnt_q <= '0;
                default: ;
            endcase

            if (state_q != IDLE && abort) begin
                abort_flag_q <= 1'b1;
            end

            // Decide the aborted status on the way into DONE so it is
            // visible together with the done pulse; it then holds until
            // the next start clears it.
            if (state_q != IDLE && state_q != DONE && state_next == DONE) begin
                aborted_q <= abort_flag_q | abort;
            end
        end
    end

    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign aborted    = aborted_q;
    assign words_left = words_left_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_dma_bus_controller.sv
`timescale 1ns/1ps
module tb_dma_bus_controller;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 8;
    localparam int LEN_W   = 8;
    localparam int BL      = 4;
    localparam int TXN_W   = 4 + ADDR_W + DATA_W;
    localparam int MAX_CYC = 400;

    logic              clk, rst_n, start, dir, abort;
    logic [ADDR_W-1:0] src_addr, dst_addr, bus_addr;
    logic [LEN_W-1:0]  len, words_left;
    logic              bus_req, bus_grant, bus_valid, bus_ready;
    logic [1:0]        bus_op, bus_type;
    logic [DATA_W-1:0] bus_rdata, bus_wdata;
    logic              busy, done, aborted;
    logic [2:0]        state_dbg;

    int n_cmp, n_fail;

    // Reference model results: every bus transaction as {op, type, addr, data}.
    logic [TXN_W-1:0]  exp_q[$];
    logic [DATA_W-1:0] rd_vals[$];
    int                exp_words, exp_releases, exp_done_cyc, exp_max_burst;
    logic [LEN_W-1:0]  exp_words_left;
    logic              exp_aborted;

    // Observations of one transfer.
    logic [TXN_W-1:0]  obs_q[$];
    int                done_cyc, done_cnt, first_rd_cyc, req_low, req_seen, max_burst, stable_err;
    logic [LEN_W-1:0]  wl_at_done;
    logic              ab_at_done, ab_after, busy_after;
    bit                timed_out;

    dma_bus_controller #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .BURST_LEN(BL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dir(dir),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len), .abort(abort),
        .bus_req(bus_req), .bus_grant(bus_grant), .bus_valid(bus_valid),
        .bus_op(bus_op), .bus_type(bus_type), .bus_addr(bus_addr),
        .bus_rdata(bus_rdata), .bus_wdata(bus_wdata), .bus_ready(bus_ready),
        .busy(busy), .done(done), .aborted(aborted), .words_left(words_left),
        .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    task automatic build_model(input logic d, input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] t,
                               input int n, input int abort_word);
        logic [ADDR_W-1:0] ra, wa;
        exp_q.delete();
        rd_vals.delete();
        exp_aborted    = (abort_word >= 0 && abort_word < n);
        exp_words      = exp_aborted ? abort_word + 1 : n;
        exp_words_left = LEN_W'(n - exp_words);
        exp_releases   = (exp_words == 0) ? 0 : (exp_words - 1) / BL;
        exp_max_burst  = (exp_words < BL) ? exp_words : BL;
        exp_done_cyc   = (n == 0) ? 1 : 2 + 3 * exp_words + 2 * exp_releases;
        for (int i = 0; i < exp_words; i++) begin
            rd_vals.push_back($urandom);
            ra = d ? s : ADDR_W'(int'(s) + i);
            wa = d ? ADDR_W'(int'(t) + i) : t;
            exp_q.push_back({2'b01, (d ? 2'b11 : 2'b00), ra, rd_vals[i]});
            exp_q.push_back({2'b00, (d ? 2'b00 : 2'b11), wa, rd_vals[i]});
        end
    endtask

    // ---------------- driver / slave / monitor ----------------
    // ready_mode: 0 always ready, 1 random waits, 2 two waits on reads and three on writes.
    task automatic run_transfer(input logic d, input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] t,
                                input int n, input int ready_mode, input bit grant_tied,
                                input int abort_word, input bit start_busy, input bit abort_with_start);
        int cyc, n_rd, n_wr, cur_burst, wcnt, gcnt;
        bit waiting, rdy, finished;
        logic [1:0] p_op, p_type;
        logic [ADDR_W-1:0] p_addr;
        obs_q.delete();
        done_cyc = -1; done_cnt = 0; first_rd_cyc = -1; req_low = 0; req_seen = 0;
        max_burst = 0; stable_err = 0; timed_out = 0;
        wl_at_done = '0; ab_at_done = 1'b0; ab_after = 1'b0; busy_after = 1'b1;
        n_rd = 0; n_wr = 0; cur_burst = 0; wcnt = 0; gcnt = 0;
        waiting = 0; finished = 0; p_op = 2'b00; p_type = 2'b00; p_addr = '0;
        @(negedge clk);
        dir = d; src_addr = s; dst_addr = t; len = LEN_W'(n);
        start = 1'b1; abort = abort_with_start;
        bus_grant = grant_tied; bus_ready = 1'b0;
        cyc = 0;
        while (!finished) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            abort = 1'b0;
            if (start_busy && cyc == 4) begin
                start = 1'b1; dir = ~d;
                src_addr = ADDR_W'($urandom); dst_addr = ADDR_W'($urandom);
                len = LEN_W'($urandom_range(1, 20));
            end
            if (bus_req) req_seen++;
            if (busy && !bus_req && !done) begin
                req_low++;
                cur_burst = 0;
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = cyc; wl_at_done = words_left; ab_at_done = aborted;
                end
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                ab_after = aborted; busy_after = busy;
            end
            if (done_cyc >= 0 && cyc == done_cyc + 2) finished = 1;
            if (cyc >= MAX_CYC) begin
                timed_out = 1; finished = 1;
            end
            // arbiter: grant some cycles after a request, hold while requested
            if (grant_tied) bus_grant = 1'b1;
            else if (!bus_req) begin
                bus_grant = 1'b0; gcnt = int'($urandom_range(0, 3));
            end else if (!bus_grant) begin
                if (gcnt == 0) bus_grant = 1'b1;
                else gcnt--;
            end
            // slave
            if (bus_valid) begin
                if (bus_op == 2'b01 && first_rd_cyc < 0) first_rd_cyc = cyc;
                if (waiting && ({bus_op, bus_type, bus_addr} !== {p_op, p_type, p_addr})) stable_err++;
                if (!waiting && bus_op == 2'b00 && n_wr == abort_word) abort = 1'b1;
                if (!waiting) wcnt = 0;
                case (ready_mode)
                    0:       rdy = 1'b1;
                    1:       rdy = ($urandom_range(0, 2) == 0);
                    default: rdy = (wcnt >= ((bus_op == 2'b01) ? 2 : 3));
                endcase
                wcnt++;
                bus_ready = rdy;
                if (bus_op == 2'b01)
                    bus_rdata = (rdy && n_rd < rd_vals.size()) ? rd_vals[n_rd] : $urandom;
                if (rdy) begin
                    obs_q.push_back({bus_op, bus_type, bus_addr, ((bus_op == 2'b01) ? bus_rdata : bus_wdata)});
                    if (bus_op == 2'b01) begin
                        n_rd++; cur_burst++;
                        if (cur_burst > max_burst) max_burst = cur_burst;
                    end else begin
                        n_wr++;
                    end
                    waiting = 0;
                end else begin
                    waiting = 1; p_op = bus_op; p_type = bus_type; p_addr = bus_addr;
                end
            end else begin
                waiting = 0;
                bus_ready = 1'($urandom_range(0, 1));
                bus_rdata = $urandom;
            end
        end
        start = 1'b0; abort = 1'b0; bus_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if ({bus_req, bus_valid} !== 2'b00) begin n_fail++; $display("FAIL reset_req_valid: got %b expected 00", {bus_req, bus_valid}); end
        n_cmp++; if ({bus_op, bus_type, bus_addr} !== '0) begin n_fail++; $display("FAIL reset_bus: got %h expected 0", {bus_op, bus_type, bus_addr}); end
        n_cmp++; if (bus_wdata !== '0) begin n_fail++; $display("FAIL reset_wdata: got %h expected 0", bus_wdata); end
        n_cmp++; if ({busy, done, aborted} !== 3'b000) begin n_fail++; $display("FAIL reset_status: got %b expected 000", {busy, done, aborted}); end
        n_cmp++; if (words_left !== '0) begin n_fail++; $display("FAIL reset_words_left: got %0d expected 0", words_left); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if ({busy, bus_req} !== 2'b00) begin n_fail++; $display("FAIL reset_idle_after: got %b expected 00", {busy, bus_req}); end
    endtask

    task automatic test_basic_copy();
        build_model(1'b0, 8'h10, 8'h05, 3, -1);
        run_transfer(1'b0, 8'h10, 8'h05, 3, 0, 1'b1, -1, 1'b0, 1'b0);
        n_cmp++; if (timed_out) begin n_fail++; $display("FAIL basic_timeout: got no done, expected done within %0d cycles", MAX_CYC); end
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL basic_count: got %0d txns expected %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL basic_txn[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
        n_cmp++; if (first_rd_cyc != 2) begin n_fail++; $display("FAIL basic_first_read: got cycle %0d expected 2", first_rd_cyc); end
        n_cmp++; if (done_cyc != 11) begin n_fail++; $display("FAIL basic_done_cycle: got %0d expected 11", done_cyc); end
        n_cmp++; if (done_cnt != 1) begin n_fail++; $display("FAIL basic_done_width: got %0d cycles expected 1", done_cnt); end
        n_cmp++; if (wl_at_done !== '0 || ab_at_done !== 1'b0) begin n_fail++; $display("FAIL basic_end: got words_left %0d aborted %b expected 0 0", wl_at_done, ab_at_done); end
        n_cmp++; if (busy_after !== 1'b0) begin n_fail++; $display("FAIL basic_idle: got busy %b expected 0", busy_after); end
    endtask

    task automatic test_zero_len();
        build_model(1'b0, 8'h22, 8'h33, 0, -1);
        run_transfer(1'b0, 8'h22, 8'h33, 0, 0, 1'b1, -1, 1'b0, 1'b0);
        n_cmp++; if (req_seen != 0) begin n_fail++; $display("FAIL zero_req: got %0d req cycles expected 0", req_seen); end
        n_cmp++; if (done_cyc != exp_done_cyc) begin n_fail++; $display("FAIL zero_done_cycle: got %0d expected %0d", done_cyc, exp_done_cyc); end
        n_cmp++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL zero_txns: got %0d expected 0", obs_q.size()); end
        n_cmp++; if (ab_at_done !== 1'b0 || done_cnt != 1) begin n_fail++; $display("FAIL zero_end: got aborted %b done cycles %0d expected 0 1", ab_at_done, done_cnt); end
    endtask

    task automatic test_burst_release();
        build_model(1'b0, 8'h20, 8'h30, 6, -1);
        run_transfer(1'b0, 8'h20, 8'h30, 6, 0, 1'b1, -1, 1'b0, 1'b0);
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL burst_count: got %0d txns expected %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL burst_txn[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
        n_cmp++; if (req_low != 1) begin n_fail++; $display("FAIL burst_release: got %0d release cycles expected 1", req_low); end
        n_cmp++; if (max_burst != BL) begin n_fail++; $display("FAIL burst_max: got %0d words per grant expected %0d", max_burst, BL); end
        n_cmp++; if (done_cyc != exp_done_cyc) begin n_fail++; $display("FAIL burst_done_cycle: got %0d expected %0d", done_cyc, exp_done_cyc); end
    endtask

    task automatic test_wait_states();
        logic [ADDR_W-1:0] s, t;
        s = ADDR_W'($urandom); t = ADDR_W'($urandom);
        build_model(1'b0, s, t, 3, -1);
        run_transfer(1'b0, s, t, 3, 2, 1'b1, -1, 1'b0, 1'b0);
        n_cmp++; if (stable_err != 0) begin n_fail++; $display("FAIL wait_stable: got %0d changes while waiting expected 0", stable_err); end
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL wait_count: got %0d txns expected %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL wait_txn[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
        n_cmp++; if (done_cyc != exp_done_cyc + 5 * exp_words) begin n_fail++; $display("FAIL wait_done_cycle: got %0d expected %0d", done_cyc, exp_done_cyc + 5 * exp_words); end
    endtask

    task automatic test_io_to_mem_wrap();
        logic [ADDR_W-1:0] a1, a3;
        build_model(1'b1, 8'h40, 8'hFF, 2, -1);
        run_transfer(1'b1, 8'h40, 8'hFF, 2, 0, 1'b1, -1, 1'b0, 1'b0);
        n_cmp++; if (obs_q.size() != 4) begin n_fail++; $display("FAIL wrap_count: got %0d txns expected 4", obs_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL wrap_txn[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
        if (obs_q.size() >= 4) begin
            a1 = obs_q[1][DATA_W +: ADDR_W];
            a3 = obs_q[3][DATA_W +: ADDR_W];
            n_cmp++; if (a1 !== 8'hFF || a3 !== 8'h00) begin n_fail++; $display("FAIL wrap_addr: got %h,%h expected ff,00", a1, a3); end
        end
    endtask

    task automatic test_abort();
        build_model(1'b0, 8'h50, 8'h60, 5, 1);
        run_transfer(1'b0, 8'h50, 8'h60, 5, 0, 1'b1, 1, 1'b0, 1'b0);
        n_cmp++; if (obs_q.size() != 4) begin n_fail++; $display("FAIL abort_count: got %0d txns expected 4", obs_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL abort_txn[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
        n_cmp++; if (wl_at_done !== 8'd3) begin n_fail++; $display("FAIL abort_words_left: got %0d expected 3", wl_at_done); end
        n_cmp++; if (ab_at_done !== 1'b1) begin n_fail++; $display("FAIL abort_flag: got %b expected 1", ab_at_done); end
        n_cmp++; if (ab_after !== 1'b1) begin n_fail++; $display("FAIL abort_held: got %b expected 1", ab_after); end
        n_cmp++; if (done_cyc != exp_done_cyc) begin n_fail++; $display("FAIL abort_done_cycle: got %0d expected %0d", done_cyc, exp_done_cyc); end
    endtask

    task automatic test_start_ignored();
        logic [ADDR_W-1:0] s, t;
        s = ADDR_W'($urandom); t = ADDR_W'($urandom);
        build_model(1'b0, s, t, 4, -1);
        run_transfer(1'b0, s, t, 4, 0, 1'b1, -1, 1'b1, 1'b0);
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL busy_start_count: got %0d txns expected %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL busy_start_txn[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
        n_cmp++; if (wl_at_done !== '0 || done_cyc != exp_done_cyc) begin n_fail++; $display("FAIL busy_start_end: got words_left %0d done %0d expected 0 %0d", wl_at_done, done_cyc, exp_done_cyc); end
    endtask

    task automatic test_start_abort_idle();
        build_model(1'b1, 8'h07, 8'h80, 2, -1);
        run_transfer(1'b1, 8'h07, 8'h80, 2, 0, 1'b1, -1, 1'b0, 1'b1);
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL start_abort_count: got %0d txns expected %0d", obs_q.size(), exp_q.size()); end
        n_cmp++; if (ab_at_done !== 1'b0) begin n_fail++; $display("FAIL start_abort_flag: got %b expected 0", ab_at_done); end
    endtask

    task automatic test_random();
        logic d;
        logic [ADDR_W-1:0] s, t;
        int n, rm, aw;
        bit gt;
        for (int it = 0; it < 16; it++) begin
            d  = 1'($urandom_range(0, 1));
            s  = ADDR_W'($urandom);
            t  = ADDR_W'($urandom);
            n  = int'($urandom_range(1, 10));
            rm = int'($urandom_range(0, 1));
            gt = 1'($urandom_range(0, 1));
            aw = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, n)) : -1;
            build_model(d, s, t, n, aw);
            run_transfer(d, s, t, n, rm, gt, aw, 1'b0, 1'b0);
            n_cmp++; if (timed_out) begin n_fail++; $display("FAIL rand%0d_timeout: got no done expected done within %0d cycles", it, MAX_CYC); end
            n_cmp++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand%0d_count: got %0d txns expected %0d", it, obs_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
                n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand%0d_txn[%0d]: got %h expected %h", it, i, obs_q[i], exp_q[i]); end
            end
            n_cmp++; if (wl_at_done !== exp_words_left) begin n_fail++; $display("FAIL rand%0d_words_left: got %0d expected %0d", it, wl_at_done, exp_words_left); end
            n_cmp++; if (ab_at_done !== exp_aborted) begin n_fail++; $display("FAIL rand%0d_aborted: got %b expected %b", it, ab_at_done, exp_aborted); end
            n_cmp++; if (req_low != exp_releases) begin n_fail++; $display("FAIL rand%0d_release: got %0d expected %0d", it, req_low, exp_releases); end
            n_cmp++; if (max_burst != exp_max_burst) begin n_fail++; $display("FAIL rand%0d_burst: got %0d expected %0d", it, max_burst, exp_max_burst); end
            n_cmp++; if (stable_err != 0 || done_cnt != 1) begin n_fail++; $display("FAIL rand%0d_handshake: got %0d changes, %0d done cycles expected 0, 1", it, stable_err, done_cnt); end
            if (rm == 0 && gt) begin
                n_cmp++; if (done_cyc != exp_done_cyc) begin n_fail++; $display("FAIL rand%0d_done_cycle: got %0d expected %0d", it, done_cyc, exp_done_cyc); end
            end
        end
    endtask

    task automatic test_reset_mid_read();
        bit saw, done_seen;
        @(negedge clk);
        dir = 1'b0; src_addr = 8'h33; dst_addr = 8'h44; len = 8'd4;
        start = 1'b1; abort = 1'b0; bus_grant = 1'b1; bus_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        saw = 0;
        for (int k = 0; k < 10 && !saw; k++) begin
            if (bus_valid && bus_op == 2'b01) saw = 1;
            else @(negedge clk);
        end
        n_cmp++; if (!saw) begin n_fail++; $display("FAIL rstmid_reach: got no read cycle expected one"); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL rstmid_req: got %b expected 0", bus_req); end
        n_cmp++; if ({bus_valid, bus_op, bus_type, bus_addr, bus_wdata, busy, done, aborted, words_left} !== '0)
            begin n_fail++; $display("FAIL rstmid_outputs: got nonzero %h expected 0", {bus_valid, bus_op, bus_type, bus_addr, bus_wdata, busy, done, aborted, words_left}); end
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (done || busy) done_seen = 1;
        end
        n_cmp++; if (done_seen) begin n_fail++; $display("FAIL rstmid_no_done: got done/busy after reset expected idle"); end
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        rst_n = 1'b0; start = 1'b0; dir = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
        abort = 1'b0; bus_grant = 1'b0; bus_rdata = '0; bus_ready = 1'b0;
        test_reset();
        test_basic_copy();
        test_zero_len();
        test_burst_release();
        test_wait_states();
        test_io_to_mem_wrap();
        test_abort();
        test_start_ignored();
        test_start_abort_idle();
        test_random();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
